// File: rtl/controlador_mdio.sv
// MDIO management-frame master: serialises a 32-bit frame on MDIO at CLK/2 and captures read data.
// Define MDIO_PREAMBLE_EN to prefix every frame with 32 bit periods of ones.
module controlador_mdio (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MDC_START,
   input  logic [31:0] T_DATA,
   input  logic        MDIO_IN,
   output logic        MDC,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   output logic        MDIO_DONE,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY
);

   localparam int unsigned FRAME_W = 32;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned CNT_W   = 6;

   // Half-bit counts (CLK edges after phase entry) at which a phase ends
   localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(63);
   localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(31);

`ifdef MDIO_PREAMBLE_EN
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PREAMBLE  = 2'd1,
      SHIFT_OUT = 2'd2,
      SHIFT_IN  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT_OUT = 2'd2,
      SHIFT_IN  = 2'd3
   } state_t;
`endif

   state_t              state_q, state_d;
   logic                mdc_q, mdc_d;
   logic                out_q, out_d;
   logic                oe_q, oe_d;
   logic                done_q, done_d;
   logic                rdy_q, rdy_d;
   logic                rd_op_q, rd_op_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // State and datapath registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         mdc_q   <= 1'b0;
         out_q   <= 1'b0;
         oe_q    <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
         rd_op_q <= 1'b0;
         rd_q    <= '0;
         sh_q    <= '0;
         frame_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mdc_q   <= mdc_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
         rd_op_q <= rd_op_d;
         rd_q    <= rd_d;
         sh_q    <= sh_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output logic; a bit boundary is an edge where MDC falls (mdc_q == 1)
   always_comb begin
      state_d = state_q;
      mdc_d   = mdc_q;
      out_d   = out_q;
      oe_d    = oe_q;
      done_d  = 1'b0;
      rdy_d   = 1'b0;
      rd_op_d = rd_op_q;
      rd_d    = rd_q;
      sh_d    = sh_q;
      frame_d = frame_q;
      cnt_d   = cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            mdc_d = 1'b0;
            oe_d  = 1'b0;
            out_d = 1'b0;
            cnt_d = '0;
            if (MDC_START) begin
               frame_d = T_DATA;
               rd_op_d = (T_DATA[29:28] == 2'b10);
               oe_d    = 1'b1;
`ifdef MDIO_PREAMBLE_EN
               state_d = PREAMBLE;
               out_d   = 1'b1;
`else
               state_d = SHIFT_OUT;
               out_d   = T_DATA[31];
`endif
            end
         end

`ifdef MDIO_PREAMBLE_EN
         PREAMBLE: begin
            mdc_d = ~mdc_q;
            if (mdc_q && (cnt_q == LAST_FULL)) begin
               state_d = SHIFT_OUT;
               out_d   = frame_q[31];
               cnt_d   = '0;
            end
         end
`endif

         SHIFT_OUT: begin
            mdc_d = ~mdc_q;
            if (mdc_q) begin
               if (rd_op_q && (cnt_q == LAST_HALF)) begin
                  state_d = SHIFT_IN;
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
                  cnt_d   = '0;
               end else if (cnt_q == LAST_FULL) begin
                  state_d = IDLE;
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  frame_d = {frame_q[30:0], frame_q[31]};
                  out_d   = frame_q[30];
               end
            end
         end

         SHIFT_IN: begin
            mdc_d = ~mdc_q;
            if (!mdc_q) begin
               sh_d = {sh_q[DATA_W-2:0], MDIO_IN};
            end else if (cnt_q == LAST_HALF) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               out_d   = 1'b0;
               done_d  = 1'b1;
               rdy_d   = 1'b1;
               rd_d    = sh_q;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
            mdc_d   = 1'b0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   assign MDC       = mdc_q;
   assign MDIO_OUT  = out_q;
   assign MDIO_OE   = oe_q;
   assign MDIO_DONE = done_q;
   assign RD_DATA   = rd_q;
   assign DATA_RDY  = rdy_q;

endmodule
